// File: rtl/signed_seq_mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package signed_seq_mult_pkg;

  localparam int ZERO = 0;
  localparam int ONE  = 1;
  localparam int TWO  = 2;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } mult_state_e;

endpackage

// File: rtl/signed_seq_mult_twos_neg.sv
// Conditional two's-complement negation: y = en ? -x : x, at width W.
module twos_neg #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/signed_seq_mult.sv
// Sequential signed/unsigned shift-add multiplier with start/done handshake.
// Optional early exit on an exhausted multiplier is enabled by MULT_EARLY_EXIT_EN.
module signed_seq_mult
  import signed_seq_mult_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic            busy,
  output logic            done,
  output logic            sign,
  output logic [2*DW-1:0] result
);

  localparam int PW = TWO * DW;
  localparam int CW = $clog2(DW) + ONE;

  mult_state_e state, state_next;

  logic [DW-1:0] a_reg, b_reg;
  logic          mode_reg;
  logic [DW-1:0] mcand_mag, mplier;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          neg_flag;

  logic [DW-1:0] mag_a, mag_b;
  logic [DW:0]   sum;
  logic [PW-1:0] acc_step;
  logic [DW-1:0] mplier_step;
  logic [CW-1:0] cnt_step;
  logic          calc_last;
  logic [PW-1:0] product, product_fixed;
  logic          fix_neg;

  twos_neg #(.W(DW)) u_neg_a (.en(mode_reg & a_reg[DW-1]), .x(a_reg), .y(mag_a));
  twos_neg #(.W(DW)) u_neg_b (.en(mode_reg & b_reg[DW-1]), .x(b_reg), .y(mag_b));
  twos_neg #(.W(PW)) u_neg_p (.en(fix_neg), .x(product), .y(product_fixed));

  // The carry out of the upper-half add becomes the new MSB after the shift.
  assign sum         = {1'b0, acc[PW-1:DW]} + (mplier[0] ? {1'b0, mcand_mag} : '0);
  assign acc_step    = {sum, acc[DW-1:1]};
  assign mplier_step = mplier >> 1;
  assign cnt_step    = cnt + CW'(ONE);

`ifdef MULT_EARLY_EXIT_EN
  // After cnt iterations the product sits DW-cnt bits too high; realign it.
  assign calc_last = (cnt_step == CW'(DW)) || (mplier_step == '0);
  assign product   = acc >> (CW'(DW) - cnt);
`else
  assign calc_last = (cnt_step == CW'(DW));
  assign product   = acc;
`endif

  assign fix_neg = neg_flag && (product != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD:    state_next = CALC;
      CALC:    if (calc_last) state_next = FIX;
      FIX:     state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= 1'b0;
      mcand_mag <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_flag  <= 1'b0;
      sign      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= multiplicand;
            b_reg    <= multiplier;
            mode_reg <= signed_mode;
          end
        end
        LOAD: begin
          mcand_mag <= mag_a;
          mplier    <= mag_b;
          neg_flag  <= mode_reg & (a_reg[DW-1] ^ b_reg[DW-1]);
          acc       <= '0;
          cnt       <= '0;
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier_step;
          cnt    <= cnt_step;
        end
        FIX: begin
          result <= product_fixed;
          sign   <= fix_neg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/signed_seq_mult.md
# signed_seq_mult

Parametrised sequential shift-add multiplier for the P01 datapath. It generalises the two's-complement sign-correction stage into a full multiply engine with operand width DW and a runtime signed/unsigned mode. It converts operands to magnitudes, performs DW shift-add iterations, and applies two's-complement negation to the 2·DW-bit product. It sits between the operand-capture registers and the display/result formatter, with a start/done handshake.

## Interface
- DW, 16, operand width in bits (≥ 4); product width is 2·DW
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured with start
- multiplicand  input  DW  operand A; captured with start
- multiplier  input  DW  operand B; captured with start
- busy  output  1  high from the edge after start is accepted until done
- done  output  1  single-cycle pulse; result valid from this cycle
- sign  output  1  sign of the result (0 in unsigned mode or for a zero product)
- result  output  2·DW  product; two's complement in signed mode, unsigned otherwise; held until the next accepted start

## Operation
- States: IDLE → LOAD → CALC → FIX → DONE → IDLE.
- IDLE: start=1 captures operands and mode, then goes to LOAD. start=0 stays in IDLE.
- LOAD:
  - Signed mode: each magnitude = operand MSB ? −operand : operand, held as a DW-bit unsigned value. −2^(DW−1) yields 2^(DW−1) exactly.
  - neg_flag = MSB_A ^ MSB_B (signed mode only).
  - Unsigned mode: magnitudes = operands, neg_flag = 0.
- CALC: one iteration per cycle.
  - If the multiplier-magnitude LSB is 1, add the multiplicand magnitude to the upper half of the 2·DW accumulator.
  - Shift the accumulator and multiplier register right.
  - Exactly DW iterations, counted by an iteration counter of width clog2(DW)+1.
- FIX:
  - result = neg_flag && product≠0 ? −product (2·DW-bit two's complement) : product.
  - sign = neg_flag && product≠0.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic is exact for all inputs; no overflow exists. Worst signed case (−2^(DW−1))² = 2^(2DW−2) fits positive.
- start while busy is ignored. Operand changes after capture have no effect.
- Reset, including mid-operation:
  - State goes to IDLE; accumulator and counter are cleared.
  - busy=0, done=0, sign=0, result=0.

## Timing
- Start sampled high at edge 0 → LOAD at edge 1 → CALC occupies edges 2..DW+1 → FIX at edge DW+2.
- FIX updates result and sign at edge DW+2. done is high between edges DW+2 and DW+3.
- Latency is fixed at DW+2 edges, e.g. 18 for DW=16, unless the early-exit option is enabled.
- busy is high after edge 0 through the done cycle, then low.
- Back-to-back operation: a start coincident with done is ignored. The next start is accepted at the first IDLE edge.

## Configuration
- MULT_EARLY_EXIT_EN defined:
  - CALC leaves to FIX after any iteration at which the remaining shifted multiplier-magnitude register is zero.
  - At least one iteration is always performed.
  - The accumulator is aligned by the remaining shift count, so result values are identical to the non-early-exit build.
  - Latency = k+2 edges, where k = max(1, bit length of the multiplier magnitude).
- MULT_EARLY_EXIT_EN undefined: fixed DW iterations, fixed latency DW+2.

## Structure
- Pkg_Global gains:
  - the DW default constant;
  - a mult_state_e enum typedef (IDLE, LOAD, CALC, FIX, DONE).
- Existing constants (ZERO, ONE, TWO) are reused.
- One sub-module, twos_neg: combinational, parametrised width, y = en ? (~x + 1) : x. It is instantiated for operand magnitudes (width DW) and result correction (width 2·DW).

## Test plan
- DW=16, signed, 7 × −3 → result 0xFFFF_FFEB, sign=1, done at edge 18.
- Signed, −32768 × −32768 → result 0x4000_0000, sign=0.
- Unsigned, 0xFFFF × 0xFFFF → result 0xFFFE_0001, sign=0; the same inputs in signed mode → 0x0000_0001, sign=0.
- Signed, −5 × 0 → result 0, sign=0.
- Two start edges:
  - start pulsed again at edge 5 of an operation → ignored; first result unchanged.
  - rst asserted at edge 8 of CALC → busy/done/sign/result = 0 immediately; a following 2 × 2 completes normally with result 4.
- MULT_EARLY_EXIT_EN defined:
  - 3 × 5 → result 15, done at edge 5.
  - 9 × 0 → result 0, done at edge 3.
